// File: rtl/lpc_decoder.sv
// Product-parity word decoder: syndrome check, single-bit correction (LPC_DEC_CORRECT_EN) or detect-only, 4x16b beats.
// Latency: accept at t, beat 0 valid at t+2; min 6 cycles per word.
// Backpressure: M_TREADY low holds the current beat; IN_READY stays low until beat 3 handshakes.
module lpc_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic [79:0]      IN_DATA,
  input  logic             IN_VALID,
  input  logic             IN_LAST,
  output logic             IN_READY,
  output logic [15:0]      M_TDATA,
  output logic             M_TVALID,
  input  logic             M_TREADY,
  output logic             M_TUSER,
  output logic             M_TLAST,
  output logic             M_TERR,
  output logic             M_TCORR,
  output logic [CNT_W-1:0] CNT_CORR,
  output logic [CNT_W-1:0] CNT_UNCORR
);

  typedef enum logic [1:0] {ST_IDLE, ST_CHECK, ST_SEND} state_t;

  typedef struct packed {
    logic [7:0]  ph;
    logic [7:0]  pv;
    logic [63:0] src;
  } lpc_word_t;

  state_t           state_q, state_d;
  lpc_word_t        word_q;
  logic             last_q, err_q, corr_q;
  logic [1:0]       beat_q;
  logic [CNT_W-1:0] cnt_corr_q, cnt_uncorr_q;
  logic [7:0]       rs, cs;
  logic [63:0]      flip_mask;
  logic             chk_err, chk_corr;

  // Row syndrome per byte; column syndrome folds all bytes against ph.
  always_comb begin
    rs = '0;
    cs = word_q.ph;
    for (int i = 0; i < 8; i++) begin
      rs[i] = word_q.pv[i] ^ (^word_q.src[8*i +: 8]);
      cs    = cs ^ word_q.src[8*i +: 8];
    end
  end

  always_comb begin
    flip_mask = '0;
    chk_err   = 1'b0;
    chk_corr  = 1'b0;
`ifdef LPC_DEC_CORRECT_EN
    if ($onehot(rs) && $onehot(cs)) begin
      // Outer product of two one-hot syndromes marks exactly the faulty data bit.
      for (int i = 0; i < 8; i++)
        flip_mask[8*i +: 8] = rs[i] ? cs : 8'h00;
      chk_corr = 1'b1;
    end else if (($onehot(rs) && cs == 8'h00) || (rs == 8'h00 && $onehot(cs))) begin
      chk_corr = 1'b1;
    end else if (rs != 8'h00 || cs != 8'h00) begin
      chk_err = 1'b1;
    end
`else
    chk_err = |{rs, cs};
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (IN_VALID) state_d = ST_CHECK;
      ST_CHECK: state_d = ST_SEND;
      ST_SEND:  if (M_TREADY && beat_q == 2'd3) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q      <= ST_IDLE;
      word_q       <= '0;
      last_q       <= 1'b0;
      err_q        <= 1'b0;
      corr_q       <= 1'b0;
      beat_q       <= 2'd0;
      cnt_corr_q   <= '0;
      cnt_uncorr_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (IN_VALID) begin
            word_q <= lpc_word_t'(IN_DATA);
            last_q <= IN_LAST;
          end
        end
        ST_CHECK: begin
          word_q.src <= word_q.src ^ flip_mask;
          err_q      <= chk_err;
          corr_q     <= chk_corr;
          beat_q     <= 2'd0;
          if (chk_corr && cnt_corr_q != {CNT_W{1'b1}})
            cnt_corr_q <= cnt_corr_q + CNT_W'(1);
          if (chk_err && cnt_uncorr_q != {CNT_W{1'b1}})
            cnt_uncorr_q <= cnt_uncorr_q + CNT_W'(1);
        end
        ST_SEND: begin
          if (M_TREADY) beat_q <= beat_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Beat k carries src[2k] in the upper byte and src[2k+1] in the lower byte.
  always_comb begin
    M_TDATA = '0;
    if (M_TVALID)
      M_TDATA = {word_q.src[{beat_q, 4'd0} +: 8], word_q.src[{beat_q, 4'd8} +: 8]};
  end

  assign IN_READY   = (state_q == ST_IDLE);
  assign M_TVALID   = (state_q == ST_SEND);
  assign M_TUSER    = M_TVALID && (beat_q == 2'd0);
  assign M_TLAST    = M_TVALID && (beat_q == 2'd3) && last_q;
  assign M_TERR     = M_TVALID && err_q;
  assign M_TCORR    = M_TVALID && corr_q;
  assign CNT_CORR   = cnt_corr_q;
  assign CNT_UNCORR = cnt_uncorr_q;

endmodule
